// File: rtl/boot_pkg.sv
// boot_pkg: state encodings, target selects and widths shared by the boot sequencer files.
package boot_pkg;
  localparam int ADDR_W = 17;
  localparam int BUS_ADDR_W = 15;
  localparam int DATA_W = 8;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_SETUP,
    ST_WRITE,
    ST_HOLD,
    ST_DONE
  } state_e;
  typedef enum logic [1:0] {
    TGT_CONTROL       = 2'b00,
    TGT_MLU_SLICE     = 2'b01,
    TGT_MLU_LOOKAHEAD = 2'b10,
    TGT_RESERVED      = 2'b11
  } target_e;
endpackage

// File: rtl/boot_sequencer_if.sv
// boot_sequencer_if: EEPROM read port, target RAM write bus and boot status of the boot sequencer.
interface boot_sequencer_if;
  import boot_pkg::*;
  logic                  REBOOT;
  logic [ADDR_W-1:0]     EEPROM_ADDR;
  logic                  EEPROM_N_OE;
  logic [DATA_W-1:0]     EEPROM_DATA;
  logic [BUS_ADDR_W-1:0] BUS_ADDR;
  logic [DATA_W-1:0]     BUS_DATA;
  logic                  BUS_OE;
  logic                  CONTROL_N_WE;
  logic                  MLU_SLICE_N_WE;
  logic                  MLU_LOOKAHEAD_N_WE;
  logic                  N_BOOTED;
  modport master (
    input  REBOOT, EEPROM_DATA,
    output EEPROM_ADDR, EEPROM_N_OE, BUS_ADDR, BUS_DATA, BUS_OE,
           CONTROL_N_WE, MLU_SLICE_N_WE, MLU_LOOKAHEAD_N_WE, N_BOOTED
  );
  modport slave (
    output REBOOT, EEPROM_DATA,
    input  EEPROM_ADDR, EEPROM_N_OE, BUS_ADDR, BUS_DATA, BUS_OE,
           CONTROL_N_WE, MLU_SLICE_N_WE, MLU_LOOKAHEAD_N_WE, N_BOOTED
  );
endinterface

// File: rtl/boot_wait_counter.sv
// boot_wait_counter: loadable 4-bit down-counter that stops at zero and flags it.
module boot_wait_counter (
  input  logic       CLK,
  input  logic       N_RST,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       zero_o
);
  logic [3:0] cnt_q, cnt_d;
  assign zero_o = cnt_q == 4'd0;
  always_comb cnt_d = load_i ? load_val_i : zero_o ? cnt_q : cnt_q - 4'd1;
  always_ff @(posedge CLK or negedge N_RST)
    if (!N_RST) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/boot_sequencer.sv
// boot_sequencer: copies boot EEPROM bytes into the CONTROL / MLU_SLICE / MLU_LOOKAHEAD RAMs,
// one byte per READ-SETUP-WRITE-HOLD pass, then parks in DONE until REBOOT.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int unsigned       READ_WAIT = 2,
  parameter int unsigned       WE_CYCLES = 1,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 17'h1FFFF
) (
  input logic              CLK,
  input logic              N_RST,
  boot_sequencer_if.master bus
);
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [2:0]          n_we_q, n_we_d;
  logic                wait_zero, wait_load, read_done, last, reserved, advance, wr;
  logic [3:0]          wait_val;
  target_e             tgt;
  assign tgt       = target_e'(addr_q[ADDR_W-1:ADDR_W-2]);
  assign reserved  = tgt == TGT_RESERVED;
  assign last      = addr_q == LAST_ADDR;
  assign read_done = state_q == ST_READ && wait_zero;
  assign advance   = (state_q == ST_HOLD || (read_done && reserved)) && !last;
  // Timer reloads whenever the current state is untimed or its wait has just expired,
  // so it is always primed for whichever timed state comes next.
  assign wait_load = !((state_q == ST_READ || state_q == ST_WRITE) && !wait_zero);
  assign wait_val  = state_d == ST_WRITE ? 4'(WE_CYCLES - 1) : 4'(READ_WAIT - 1);
  boot_wait_counter u_wait (
    .CLK       (CLK),
    .N_RST     (N_RST),
    .load_i    (wait_load),
    .load_val_i(wait_val),
    .zero_o    (wait_zero)
  );
  always_ff @(posedge CLK or negedge N_RST)
    if (!N_RST) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      n_we_q  <= 3'b111;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      n_we_q  <= n_we_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_READ;
      ST_READ:  state_d = !wait_zero ? ST_READ : !reserved ? ST_SETUP : last ? ST_DONE : ST_READ;
      ST_SETUP: state_d = ST_WRITE;
      ST_WRITE: state_d = wait_zero ? ST_HOLD : ST_WRITE;
      ST_HOLD:  state_d = last ? ST_DONE : ST_READ;
      ST_DONE:  state_d = bus.REBOOT ? ST_IDLE : ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end
  // Write enables are registered from the next state so they are clean flop outputs.
  always_comb begin
    addr_d = (state_q == ST_DONE && bus.REBOOT) ? '0 : advance ? addr_q + ADDR_W'(1) : addr_q;
    data_d = read_done ? bus.EEPROM_DATA : data_q;
    wr     = state_d == ST_WRITE;
    n_we_d = {!(wr && tgt == TGT_MLU_LOOKAHEAD), !(wr && tgt == TGT_MLU_SLICE), !(wr && tgt == TGT_CONTROL)};
    bus.EEPROM_ADDR        = addr_q;
    bus.EEPROM_N_OE        = state_q != ST_READ;
    bus.BUS_ADDR           = addr_q[BUS_ADDR_W-1:0];
    bus.BUS_DATA           = data_q;
    bus.BUS_OE             = state_q inside {ST_SETUP, ST_WRITE, ST_HOLD};
    bus.CONTROL_N_WE       = n_we_q[0];
    bus.MLU_SLICE_N_WE     = n_we_q[1];
    bus.MLU_LOOKAHEAD_N_WE = n_we_q[2];
    bus.N_BOOTED           = state_q != ST_DONE;
  end
endmodule
